// File: rtl/alu_flag_commit.sv
// Collects nibble-serial ALU results into a byte, derives Z/N/H/C and commits
// them to F; also handles SCF/CCF/POP AF and condition-code evaluation.
module alu_flag_commit #(
   parameter bit F_LOW_ZERO = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] alu_res,
   input  logic       alu_cout,
   input  logic       alu_l,
   input  logic       alu_h,
   input  logic       alu_ne,
   input  logic       c_sel,
   input  logic       wr_z,
   input  logic       wr_n,
   input  logic       wr_h,
   input  logic       wr_c,
   input  logic       scf,
   input  logic       ccf,
   input  logic       ld_f,
   input  logic [7:0] dbus,
   input  logic [1:0] cc,
   output logic [7:0] result,
   output logic       result_valid,
   output logic [7:0] f_out,
   output logic       cc_true,
   output logic       seq_err
);

   typedef enum logic {
      IDLE    = 1'b0,
      LO_HELD = 1'b1
   } state_t;

   state_t     state, state_nx;
   logic [3:0] lo_nib;
   logic       lo_cout;
   logic       lo_zero;
   logic       flag_z, flag_n, flag_h, flag_c;
   logic [3:0] low4;

   // alu_l / alu_h are single-cycle qualifiers with no backpressure: the ALU
   // presents a nibble for exactly one cycle and this block must take it.
   logic       lo_cap, commit, do_scf, do_ccf;
   logic [3:0] eff_nib;
   logic       eff_zero, eff_cout;

   always_comb begin
      lo_cap   = alu_l & ~ld_f;
      commit   = alu_h & ~alu_l & ~ld_f;
      do_scf   = scf & ~ld_f & ~commit;
      do_ccf   = ccf & ~scf & ~ld_f & ~commit;
      // A high nibble with nothing held behaves as if a zero low nibble preceded it.
      eff_nib  = 4'h0;
      eff_zero = 1'b1;
      eff_cout = 1'b0;
      if (state == LO_HELD) begin
         eff_nib  = lo_nib;
         eff_zero = lo_zero;
         eff_cout = lo_cout;
      end
   end

   always_comb begin
      state_nx = state;
      if (ld_f)
         state_nx = IDLE;
      else if (alu_l)
         state_nx = LO_HELD;
      else if (alu_h)
         state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lo_nib  <= 4'h0;
         lo_cout <= 1'b0;
         lo_zero <= 1'b0;
      end else if (lo_cap) begin
         lo_nib  <= alu_res;
         lo_cout <= alu_cout;
         lo_zero <= (alu_res == 4'h0);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         result       <= 8'h00;
         result_valid <= 1'b0;
         seq_err      <= 1'b0;
      end else begin
         result_valid <= commit;
         if (commit) begin
            result <= {alu_res, eff_nib};
            if (state == IDLE)
               seq_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flag_z <= 1'b0;
         flag_n <= 1'b0;
         flag_h <= 1'b0;
         flag_c <= 1'b0;
         low4   <= 4'h0;
      end else if (ld_f) begin
         {flag_z, flag_n, flag_h, flag_c} <= dbus[7:4];
         low4 <= F_LOW_ZERO ? 4'h0 : dbus[3:0];
      end else if (commit) begin
         if (wr_z) flag_z <= eff_zero & (alu_res == 4'h0);
         if (wr_n) flag_n <= alu_ne;
         if (wr_h) flag_h <= eff_cout;
         // Right shifts lose their carry out of the low nibble, hence c_sel.
         if (wr_c) flag_c <= c_sel ? eff_cout : alu_cout;
      end else if (do_scf) begin
         flag_c <= 1'b1;
         flag_n <= 1'b0;
         flag_h <= 1'b0;
      end else if (do_ccf) begin
         flag_c <= ~flag_c;
         flag_n <= 1'b0;
         flag_h <= 1'b0;
      end
   end

   assign f_out = {flag_z, flag_n, flag_h, flag_c, low4};

   always_comb begin
      cc_true = 1'b0;
      case (cc)
         2'd0: cc_true = ~flag_z;
         2'd1: cc_true = flag_z;
         2'd2: cc_true = ~flag_c;
         2'd3: cc_true = flag_c;
         default: cc_true = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_alu_flag_commit.sv
// Directed-vector bench for alu_flag_commit with hand-computed expectations.
module tb_alu_flag_commit;

   logic       clk;
   logic       reset_n;
   logic [3:0] alu_res;
   logic       alu_cout, alu_l, alu_h, alu_ne, c_sel;
   logic       wr_z, wr_n, wr_h, wr_c;
   logic       scf, ccf, ld_f;
   logic [7:0] dbus;
   logic [1:0] cc;
   logic [7:0] result;
   logic       result_valid;
   logic [7:0] f_out;
   logic       cc_true;
   logic       seq_err;

   int n_vec = 0;
   int n_err = 0;

   alu_flag_commit #(.F_LOW_ZERO(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .alu_res(alu_res), .alu_cout(alu_cout),
      .alu_l(alu_l), .alu_h(alu_h), .alu_ne(alu_ne), .c_sel(c_sel),
      .wr_z(wr_z), .wr_n(wr_n), .wr_h(wr_h), .wr_c(wr_c),
      .scf(scf), .ccf(ccf), .ld_f(ld_f), .dbus(dbus), .cc(cc),
      .result(result), .result_valid(result_valid), .f_out(f_out),
      .cc_true(cc_true), .seq_err(seq_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%02h, want 0x%02h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      alu_res = 4'h0; alu_cout = 1'b0; alu_l = 1'b0; alu_h = 1'b0;
      alu_ne = 1'b0; c_sel = 1'b0;
      wr_z = 1'b0; wr_n = 1'b0; wr_h = 1'b0; wr_c = 1'b0;
      scf = 1'b0; ccf = 1'b0; ld_f = 1'b0; dbus = 8'h00;
   endtask

   // Each driver applies its inputs for one clock, then checks happen #1 after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic low_nib(input logic [3:0] res, input logic cout);
      alu_l = 1'b1; alu_res = res; alu_cout = cout;
      tick();
   endtask

   task automatic high_nib(input logic [3:0] res, input logic cout, input logic sel,
                           input logic ne, input logic [3:0] wr);
      alu_h = 1'b1; alu_res = res; alu_cout = cout; c_sel = sel; alu_ne = ne;
      {wr_z, wr_n, wr_h, wr_c} = wr;
      tick();
   endtask

   task automatic load_f(input logic [7:0] d);
      ld_f = 1'b1; dbus = d;
      tick();
   endtask

   initial begin
      idle_inputs();
      cc = 2'd0;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_result", result, 8'h00);
      check("rst_f", f_out, 8'h00);
      check("rst_valid", {7'h0, result_valid}, 8'h00);
      check("rst_seq_err", {7'h0, seq_err}, 8'h00);
      check("rst_cc_nz", {7'h0, cc_true}, 8'h01);
      reset_n = 1'b1;
      tick();

      // SRA 0x81: carry comes from the low nibble's shift-out
      low_nib(4'h0, 1'b1);
      check("sra81_no_early_valid", {7'h0, result_valid}, 8'h00);
      high_nib(4'hC, 1'b0, 1'b1, 1'b0, 4'b1111);
      check("sra81_result", result, 8'hC0);
      check("sra81_f", f_out, 8'h30);
      check("sra81_valid", {7'h0, result_valid}, 8'h01);
      cc = 2'd3;
      #1 check("sra81_cc_c", {7'h0, cc_true}, 8'h01);
      cc = 2'd0;
      #1 check("sra81_cc_nz", {7'h0, cc_true}, 8'h01);
      tick();
      check("sra81_valid_drop", {7'h0, result_valid}, 8'h00);
      check("sra81_result_hold", result, 8'hC0);

      // SRA 0x01 with H masked off (H cleared first)
      load_f(8'h00);
      low_nib(4'h0, 1'b1);
      high_nib(4'h0, 1'b0, 1'b1, 1'b0, 4'b1101);
      check("sra01_result", result, 8'h00);
      check("sra01_f", f_out, 8'h90);
      cc = 2'd1;
      #1 check("sra01_cc_z", {7'h0, cc_true}, 8'h01);
      cc = 2'd2;
      #1 check("sra01_cc_nc", {7'h0, cc_true}, 8'h00);

      // ADD 0x0F+0x01: half-carry from the low nibble, C from the high nibble
      low_nib(4'h0, 1'b1);
      high_nib(4'h1, 1'b0, 1'b0, 1'b0, 4'b1111);
      check("add_result", result, 8'h10);
      check("add_f", f_out, 8'h20);
      cc = 2'd2;
      #1 check("add_cc_nc", {7'h0, cc_true}, 8'h01);

      // Subtract sets N
      low_nib(4'h5, 1'b0);
      high_nib(4'h3, 1'b1, 1'b0, 1'b1, 4'b1111);
      check("sub_result", result, 8'h35);
      check("sub_f", f_out, 8'h50);

      // Write masks: Z and C preserved
      load_f(8'hF0);
      check("mask_preset", f_out, 8'hF0);
      low_nib(4'h0, 1'b0);
      high_nib(4'h0, 1'b0, 1'b0, 1'b0, 4'b0110);
      check("mask_f", f_out, 8'h90);

      // Flag-only ops
      load_f(8'hB5);
      check("ldf_b5", f_out, 8'hB0);
      scf = 1'b1;
      tick();
      check("scf", f_out, 8'h90);
      ccf = 1'b1;
      tick();
      check("ccf", f_out, 8'h80);
      ccf = 1'b1;
      tick();
      check("ccf_again", f_out, 8'h90);
      ld_f = 1'b1; dbus = 8'h40; scf = 1'b1;
      tick();
      check("ldf_beats_scf", f_out, 8'h40);

      // A commit outranks scf in the same cycle
      low_nib(4'h2, 1'b0);
      alu_h = 1'b1; alu_res = 4'h0; c_sel = 1'b0; scf = 1'b1;
      {wr_z, wr_n, wr_h, wr_c} = 4'b0000;
      tick();
      check("commit_beats_scf", f_out, 8'h40);
      check("commit_beats_scf_res", result, 8'h02);

      // ld_f abandons a held low nibble; next high nibble is out of sequence
      low_nib(4'h9, 1'b1);
      load_f(8'h00);
      check("seq_err_clean", {7'h0, seq_err}, 8'h00);

      // alu_l with alu_h is a capture only; second low overwrites the first
      alu_l = 1'b1; alu_h = 1'b1; alu_res = 4'hA; wr_z = 1'b1; wr_c = 1'b1;
      tick();
      check("lh_no_commit", {7'h0, result_valid}, 8'h00);
      low_nib(4'h6, 1'b0);
      high_nib(4'h0, 1'b1, 1'b0, 1'b0, 4'b1111);
      check("overwrite_result", result, 8'h06);
      check("overwrite_f", f_out, 8'h10);
      check("overwrite_seq_err", {7'h0, seq_err}, 8'h00);

      // Reset while a low nibble is held: nibble discarded, seq_err set
      low_nib(4'h5, 1'b1);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_f", f_out, 8'h00);
      reset_n = 1'b1;
      high_nib(4'h7, 1'b1, 1'b0, 1'b0, 4'b1111);
      check("midrst_result", result, 8'h70);
      check("midrst_f_commit", f_out, 8'h10);
      check("midrst_seq_err", {7'h0, seq_err}, 8'h01);
      tick();
      check("seq_err_sticky", {7'h0, seq_err}, 8'h01);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
